// File: rtl/fuzzy_risk_seq.sv
// fuzzy_risk_seq: multi-cycle 3x3 fuzzy rain/soil risk estimator with a serial restoring divider.
// Define RISK_CLASS_EN to add the registered risk_class output.
module fuzzy_risk_seq #(
  parameter int W = 8,
  parameter int IN_MAX = 100,
  parameter int OUT_MAX = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] rain_fall,
  input  logic [W-1:0] soil_moisture,
  output logic         out_valid,
  output logic [W-1:0] risk,
  output logic         busy
`ifdef RISK_CLASS_EN
  ,
  output logic [1:0]   risk_class
`endif
);
  localparam int H = IN_MAX / 2;
  localparam int AW0 = $clog2(9 * H * OUT_MAX + 1);
  localparam int AW = AW0 > W ? AW0 : W + 1;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] XMAX = W'(IN_MAX);
  localparam logic [W-1:0] HV = W'(H);
  localparam logic [AW-1:0] CQ = AW'(OUT_MAX / 4);
  typedef enum logic [2:0] {IDLE, FUZZ, RULE, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] rain_q, rain_d, soil_q, soil_d, risk_q, risk_d, wk_q, wk_d, w;
  logic [2:0][W-1:0] mr_q, mr_d, ms_q, ms_d;
  logic [1:0] r_q, r_d, s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] num_q, num_d, den_q, den_d, rem_q, rem_d, c;
  logic [AW:0] rem_sh;
  logic ge;
  function automatic logic [W-1:0] sat(input logic [W-1:0] x);
    return x > XMAX ? XMAX : x;
  endfunction
  function automatic logic [2:0][W-1:0] fuzz(input logic [W-1:0] x);
    logic [W-1:0] lo, hi;
    lo = x < HV ? HV - x : '0;
    hi = x > HV ? x - HV : '0;
    return {hi, HV - lo - hi, lo};
  endfunction
  always_comb begin
    state_d = state_q;
    rain_d = rain_q;
    soil_d = soil_q;
    risk_d = risk_q;
    wk_d = wk_q;
    mr_d = mr_q;
    ms_d = ms_q;
    r_d = r_q;
    s_d = s_q;
    cnt_d = cnt_q;
    num_d = num_q;
    den_d = den_q;
    rem_d = rem_q;
    w = mr_q[r_q] < ms_q[s_q] ? mr_q[r_q] : ms_q[s_q];
    c = AW'(3'(r_q) + 3'(s_q)) * CQ;
    rem_sh = {rem_q, wk_q[W-1]};
    ge = rem_sh >= {1'b0, den_q};
    case (state_q)
      IDLE: if (in_valid) begin
        rain_d = sat(rain_fall);
        soil_d = sat(soil_moisture);
        state_d = FUZZ;
      end
      FUZZ: begin
        mr_d = fuzz(rain_q);
        ms_d = fuzz(soil_q);
        num_d = '0;
        den_d = '0;
        r_d = '0;
        s_d = '0;
        state_d = RULE;
      end
      RULE: begin
        num_d = num_q + AW'(w) * c;
        den_d = den_q + AW'(w);
        s_d = s_q == 2'd2 ? 2'd0 : s_q + 2'd1;
        r_d = s_q == 2'd2 ? r_q + 2'd1 : r_q;
        // the weighted average is at most OUT_MAX < 2^W, so num>>W already lies below den
        if (r_q == 2'd2 && s_q == 2'd2) begin
          rem_d = num_d >> W;
          wk_d = num_d[W-1:0];
          cnt_d = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = ge ? AW'(rem_sh - {1'b0, den_q}) : rem_sh[AW-1:0];
        wk_d = {wk_q[W-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          risk_d = den_q == '0 ? '0 : wk_d;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rain_q <= '0;
      soil_q <= '0;
      risk_q <= '0;
      wk_q <= '0;
      mr_q <= '0;
      ms_q <= '0;
      r_q <= '0;
      s_q <= '0;
      cnt_q <= '0;
      num_q <= '0;
      den_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      rain_q <= rain_d;
      soil_q <= soil_d;
      risk_q <= risk_d;
      wk_q <= wk_d;
      mr_q <= mr_d;
      ms_q <= ms_d;
      r_q <= r_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      num_q <= num_d;
      den_q <= den_d;
      rem_q <= rem_d;
    end
  end
  assign in_ready = state_q == IDLE && !rst;
  assign busy = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign risk = risk_q;
`ifdef RISK_CLASS_EN
  logic [1:0] cls_q, cls_d;
  always_comb begin
    cls_d = risk_d < W'(OUT_MAX / 4) ? 2'd0 :
            risk_d < W'(OUT_MAX / 2) ? 2'd1 :
            risk_d < W'(3 * OUT_MAX / 4) ? 2'd2 : 2'd3;
  end
  always_ff @(posedge clk) begin
    if (rst) cls_q <= '0;
    else cls_q <= cls_d;
  end
  assign risk_class = cls_q;
`endif
endmodule

// File: tb/tb_fuzzy_risk_seq.sv
// tb_fuzzy_risk_seq: table vectors, corner sequences and random samples against an arithmetic model.
module tb_fuzzy_risk_seq;
  logic clk = 0, rst = 1;
  logic v8 = 0, v10 = 0;
  logic [7:0] rain8 = 0, soil8 = 0, risk8;
  logic [9:0] rain10 = 0, soil10 = 0, risk10;
  logic rdy8, rdy10, ov8, ov10, busy8, busy10;
`ifdef RISK_CLASS_EN
  logic [1:0] cls8, cls10;
`endif
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  fuzzy_risk_seq dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
    .rain_fall(rain8), .soil_moisture(soil8), .out_valid(ov8),
    .risk(risk8), .busy(busy8)
`ifdef RISK_CLASS_EN
    , .risk_class(cls8)
`endif
  );

  fuzzy_risk_seq #(.W(10), .IN_MAX(1000), .OUT_MAX(1000)) dut10 (
    .clk(clk), .rst(rst), .in_valid(v10), .in_ready(rdy10),
    .rain_fall(rain10), .soil_moisture(soil10), .out_valid(ov10),
    .risk(risk10), .busy(busy10)
`ifdef RISK_CLASS_EN
    , .risk_class(cls10)
`endif
  );

  typedef struct packed {int rn; int sl; int rk; int cl;} vec_t;
  vec_t tbl [6];

  function automatic int model(input int rn, input int sl, input int in_max, input int out_max);
    int h, x, y, num, den, w;
    int mr [3];
    int ms [3];
    h = in_max / 2;
    x = rn > in_max ? in_max : rn;
    y = sl > in_max ? in_max : sl;
    mr[0] = h - x > 0 ? h - x : 0;
    mr[2] = x - h > 0 ? x - h : 0;
    mr[1] = h - (x > h ? x - h : h - x);
    ms[0] = h - y > 0 ? h - y : 0;
    ms[2] = y - h > 0 ? y - h : 0;
    ms[1] = h - (y > h ? y - h : h - y);
    num = 0;
    den = 0;
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 3; s++) begin
        w = mr[r] < ms[s] ? mr[r] : ms[s];
        num += w * ((r + s) * out_max / 4);
        den += w;
      end
    return den == 0 ? 0 : num / den;
  endfunction

  function automatic int klass(input int rk, input int out_max);
    return rk < out_max / 4 ? 0 : rk < out_max / 2 ? 1 : rk < 3 * out_max / 4 ? 2 : 3;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic send(input bit wide, input int rn, input int sl, output int rk, output int lat);
    int n = 0;
    while (!(wide ? rdy10 : rdy8) && n < 100) begin @(posedge clk); #1; n++; end
    if (wide) begin rain10 = 10'(rn); soil10 = 10'(sl); v10 = 1; end
    else begin rain8 = 8'(rn); soil8 = 8'(sl); v8 = 1; end
    @(posedge clk); #1;
    v8 = 0;
    v10 = 0;
    lat = 0;
    while (!(wide ? ov10 : ov8) && lat < 100) begin @(posedge clk); #1; lat++; end
    rk = wide ? int'(risk10) : int'(risk8);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rk, lat, a0, a1, bad, n, cnt, rn, sl;
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{100, 100, 100, 3};
    tbl[2] = '{200, 100, 100, 3};
    tbl[3] = '{25, 75, 50, 2};
    tbl[4] = '{100, 0, 50, 2};
    tbl[5] = '{50, 50, 50, 2};

    repeat (3) @(posedge clk);
    #1;
    check("reset_risk", int'(risk8), 0);
    check("reset_out_valid", int'(ov8), 0);
    check("reset_busy", int'(busy8), 0);
    check("reset_in_ready_low", int'(rdy8), 0);
    rst = 0;
    #1;
    check("in_ready_after_reset", int'(rdy8), 1);

    foreach (tbl[i]) begin
      send(0, tbl[i].rn, tbl[i].sl, rk, lat);
      check($sformatf("tbl%0d_risk", i), rk, tbl[i].rk);
      check($sformatf("tbl%0d_latency", i), lat, 18);
`ifdef RISK_CLASS_EN
      check($sformatf("tbl%0d_class", i), int'(cls8), tbl[i].cl);
`endif
      @(posedge clk); #1;
      check($sformatf("tbl%0d_pulse_width", i), int'(ov8), 0);
      check($sformatf("tbl%0d_risk_held", i), int'(risk8), tbl[i].rk);
    end

    // in_valid held high: the second sample must wait for IDLE
    rain8 = 100; soil8 = 0; v8 = 1;
    a0 = -1; a1 = -1; bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (rdy8) begin
        if (a0 < 0) a0 = i;
        else if (a1 < 0) a1 = i;
      end
      if (busy8 && rdy8) bad++;
      if (ov8) check("b2b_risk", int'(risk8), 50);
      @(posedge clk); #1;
    end
    v8 = 0;
    check("b2b_spacing", a1 - a0, 20);
    check("b2b_ready_while_busy", bad, 0);
    n = 0;
    while (busy8 && n < 50) begin @(posedge clk); #1; n++; end
    check("b2b_drained", int'(busy8), 0);

    // reset in the middle of the division
    rain8 = 100; soil8 = 100; v8 = 1;
    @(posedge clk); #1;
    v8 = 0;
    repeat (12) @(posedge clk);
    #1;
    check("mid_div_busy", int'(busy8), 1);
    rst = 1;
    @(posedge clk); #1;
    check("abort_risk", int'(risk8), 0);
    check("abort_busy", int'(busy8), 0);
    check("abort_out_valid", int'(ov8), 0);
    rst = 0;
    #1;
    check("abort_in_ready", int'(rdy8), 1);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (ov8) cnt++;
    end
    check("abort_no_pulse", cnt, 0);
    send(0, 50, 50, rk, lat);
    check("after_abort_risk", rk, 50);
    check("after_abort_latency", lat, 18);

    // reset wins over a simultaneous sample
    @(posedge clk); #1;
    rst = 1; v8 = 1; rain8 = 100; soil8 = 100;
    @(posedge clk); #1;
    rst = 0; v8 = 0;
    check("rst_vs_valid_busy", int'(busy8), 0);
    @(posedge clk); #1;
    check("rst_vs_valid_not_captured", int'(busy8), 0);

    // wide instance
    send(1, 500, 500, rk, lat);
    check("w10_mid_risk", rk, 500);
    check("w10_latency", lat, 20);
    send(1, 1000, 0, rk, lat);
    check("w10_hl_risk", rk, 500);
    send(1, 1023, 1023, rk, lat);
    check("w10_sat_risk", rk, 1000);
`ifdef RISK_CLASS_EN
    check("w10_class", int'(cls10), 3);
`endif

    for (int i = 0; i < 40; i++) begin
      rn = $urandom_range(0, 255);
      sl = $urandom_range(0, 255);
      send(0, rn, sl, rk, lat);
      check($sformatf("rand8 r=%0d s=%0d", rn, sl), rk, model(rn, sl, 100, 100));
`ifdef RISK_CLASS_EN
      check($sformatf("rand8_class r=%0d s=%0d", rn, sl), int'(cls8), klass(model(rn, sl, 100, 100), 100));
`endif
    end
    for (int i = 0; i < 10; i++) begin
      rn = $urandom_range(0, 1023);
      sl = $urandom_range(0, 1023);
      send(1, rn, sl, rk, lat);
      check($sformatf("rand10 r=%0d s=%0d", rn, sl), rk, model(rn, sl, 1000, 1000));
      check("rand10_latency", lat, 20);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
